// File: rtl/speaker_arbiter_if.sv
// Request/status bundle between the sound requesters and the buzzer arbiter.
// The master side raises requests and mute; the slave (arbiter) returns the tone and status.
interface speaker_arbiter_if;
    logic       clean_reminder;
    logic       key_beep;
    logic       alarm_req;
    logic       mute;
    logic       speaker;
    logic       busy;
    logic [1:0] active_src;

    modport master (
        output clean_reminder, key_beep, alarm_req, mute,
        input  speaker, busy, active_src
    );

    modport slave (
        input  clean_reminder, key_beep, alarm_req, mute,
        output speaker, busy, active_src
    );
endinterface

// File: rtl/speaker_arbiter.sv
// Buzzer arbiter: strict-priority sharing (alarm > key > reminder) with preemption,
// per-source on/off unit patterns and an internally generated square-wave tone.
module speaker_arbiter #(
    parameter int UNIT_CYCLES = 10_000_000,
    parameter int HALF_HI     = 50_000,
    parameter int HALF_LO     = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    speaker_arbiter_if.slave bus
);
    localparam int MAX_CNT = (2 * UNIT_CYCLES > HALF_LO) ? 2 * UNIT_CYCLES : HALF_LO;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REM_LAST  = CNT_W'(2 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI_LAST   = CNT_W'(HALF_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(HALF_LO - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_REM   = 2'b01;
    localparam logic [1:0] SRC_KEY   = 2'b10;
    localparam logic [1:0] SRC_ALARM = 2'b11;

    // Alarm plays three pairs; the one entered on grant is not counted as remaining.
    localparam logic [1:0] ALARM_PAIRS_LEFT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_t;

    state_t           state_r;
    logic [1:0]       src_r;
    logic [1:0]       step_r;
    logic [CNT_W-1:0] unit_r;
    logic [CNT_W-1:0] tone_r;
    logic             phase_r;
    logic             speaker_r;
    logic             busy_r;
    logic [1:0]       active_src_r;

    state_t           adv_state_s;
    logic [CNT_W-1:0] adv_unit_s;
    logic [CNT_W-1:0] adv_tone_s;
    logic             adv_phase_s;
    logic             start_s;
    logic [1:0]       start_src_s;
    logic [1:0]       start_step_s;
    logic             idle_s;
    logic             unit_end_s;
    logic             tone_end_s;

    state_t           state_nxt_s;
    logic [1:0]       src_nxt_s;
    logic [1:0]       step_nxt_s;
    logic [CNT_W-1:0] unit_nxt_s;
    logic [CNT_W-1:0] tone_nxt_s;
    logic             phase_nxt_s;

    // Next-state decision: grants/preemption first, then pattern sequencing.
    always_comb begin
        adv_state_s  = state_r;
        adv_unit_s   = unit_r;
        adv_tone_s   = tone_r;
        adv_phase_s  = phase_r;
        start_s      = 1'b0;
        start_src_s  = SRC_NONE;
        start_step_s = 2'd0;
        idle_s       = 1'b0;

        unit_end_s = (src_r == SRC_REM) ? (unit_r == REM_LAST) : (unit_r == UNIT_LAST);
        tone_end_s = (src_r == SRC_REM) ? (tone_r == LO_LAST)  : (tone_r == HI_LAST);

        if (bus.alarm_req && (src_r != SRC_ALARM)) begin
            start_s      = 1'b1;
            start_src_s  = SRC_ALARM;
            start_step_s = ALARM_PAIRS_LEFT;
        end else if (bus.key_beep && ((state_r == ST_IDLE) || (src_r == SRC_REM))) begin
            start_s     = 1'b1;
            start_src_s = SRC_KEY;
        end else if ((state_r != ST_IDLE) && (src_r == SRC_REM) && !bus.clean_reminder) begin
            idle_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    start_s     = bus.clean_reminder;
                    start_src_s = SRC_REM;
                    idle_s      = ~bus.clean_reminder;
                end
                ST_ON: begin
                    if (unit_end_s && (src_r == SRC_KEY)) begin
                        // Key beep has no OFF phase; fall back to a due reminder.
                        start_s     = bus.clean_reminder;
                        start_src_s = SRC_REM;
                        idle_s      = ~bus.clean_reminder;
                    end else if (unit_end_s) begin
                        adv_state_s = ST_OFF;
                        adv_unit_s  = CNT_ZERO;
                        adv_tone_s  = CNT_ZERO;
                        adv_phase_s = 1'b0;
                    end else begin
                        adv_unit_s  = unit_r + CNT_ONE;
                        adv_tone_s  = tone_end_s ? CNT_ZERO : (tone_r + CNT_ONE);
                        adv_phase_s = tone_end_s ? ~phase_r : phase_r;
                    end
                end
                ST_OFF: begin
                    if (unit_end_s && (src_r == SRC_REM)) begin
                        start_s     = 1'b1;
                        start_src_s = SRC_REM;
                    end else if (unit_end_s && (step_r != 2'd0)) begin
                        start_s      = 1'b1;
                        start_src_s  = src_r;
                        start_step_s = step_r - 2'd1;
                    end else if (unit_end_s) begin
                        start_s     = bus.clean_reminder;
                        start_src_s = SRC_REM;
                        idle_s      = ~bus.clean_reminder;
                    end else begin
                        adv_unit_s = unit_r + CNT_ONE;
                    end
                end
                default: begin
                    idle_s = 1'b1;
                end
            endcase
        end

        state_nxt_s = idle_s ? ST_IDLE  : (start_s ? ST_ON        : adv_state_s);
        src_nxt_s   = idle_s ? SRC_NONE : (start_s ? start_src_s  : src_r);
        step_nxt_s  = idle_s ? 2'd0     : (start_s ? start_step_s : step_r);
        unit_nxt_s  = (idle_s || start_s) ? CNT_ZERO : adv_unit_s;
        tone_nxt_s  = (idle_s || start_s) ? CNT_ZERO : adv_tone_s;
        phase_nxt_s = (idle_s || start_s) ? 1'b0     : adv_phase_s;
    end

    // State, counters and registered outputs; mute only gates the speaker register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            src_r        <= SRC_NONE;
            step_r       <= 2'd0;
            unit_r       <= CNT_ZERO;
            tone_r       <= CNT_ZERO;
            phase_r      <= 1'b0;
            speaker_r    <= 1'b0;
            busy_r       <= 1'b0;
            active_src_r <= SRC_NONE;
        end else begin
            state_r      <= state_nxt_s;
            src_r        <= src_nxt_s;
            step_r       <= step_nxt_s;
            unit_r       <= unit_nxt_s;
            tone_r       <= tone_nxt_s;
            phase_r      <= phase_nxt_s;
            speaker_r    <= phase_nxt_s & ~bus.mute;
            busy_r       <= (state_nxt_s != ST_IDLE);
            active_src_r <= src_nxt_s;
        end
    end

    assign bus.speaker    = speaker_r;
    assign bus.busy       = busy_r;
    assign bus.active_src = active_src_r;
endmodule
